// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, flush and retire bundle between the core and reorder_buffer.
// The core drives through the master modport; the buffer uses the slave modport.
interface reorder_buffer_if #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned INS_COUNT = 4,
    parameter int unsigned WR_COUNT  = 4,
    parameter int unsigned RET_COUNT = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5
) ();
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(INS_COUNT) + 1;

    logic              alloc_req;
    logic [CNT_W-1:0]  alloc_count;
    logic [REG_W-1:0]  alloc_dest_reg   [INS_COUNT];
    logic              alloc_dest_valid [INS_COUNT];
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_idx        [INS_COUNT];

    logic              wb_valid [WR_COUNT];
    logic [IDX_W-1:0]  wb_idx   [WR_COUNT];
    logic [DATA_W-1:0] wb_data  [WR_COUNT];
    logic              wb_exc   [WR_COUNT];

    logic              flush_req;
    logic [IDX_W-1:0]  flush_idx;

    logic              ret_ready;
    logic              ret_valid      [RET_COUNT];
    logic [IDX_W-1:0]  ret_idx        [RET_COUNT];
    logic [REG_W-1:0]  ret_dest_reg   [RET_COUNT];
    logic              ret_dest_valid [RET_COUNT];
    logic [DATA_W-1:0] ret_data       [RET_COUNT];
    logic              ret_exc        [RET_COUNT];

    logic              exc_flush;
    logic [IDX_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output alloc_req, alloc_count, alloc_dest_reg, alloc_dest_valid,
        output wb_valid, wb_idx, wb_data, wb_exc,
        output flush_req, flush_idx, ret_ready,
        input  alloc_ready, alloc_idx,
        input  ret_valid, ret_idx, ret_dest_reg, ret_dest_valid, ret_data, ret_exc,
        input  exc_flush, count, empty, full
    );

    modport slave (
        input  alloc_req, alloc_count, alloc_dest_reg, alloc_dest_valid,
        input  wb_valid, wb_idx, wb_data, wb_exc,
        input  flush_req, flush_idx, ret_ready,
        output alloc_ready, alloc_idx,
        output ret_valid, ret_idx, ret_dest_reg, ret_dest_valid, ret_data, ret_exc,
        output exc_flush, count, empty, full
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: multi-lane allocate, out-of-order writeback,
// contiguous retire, pointer-rewind flush and exception-triggered full clear.
module reorder_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned INS_COUNT = 4,
    parameter int unsigned WR_COUNT  = 4,
    parameter int unsigned RET_COUNT = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    reorder_buffer_if.slave rob
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned PTR_W     = IDX_W + 1;
    localparam int unsigned CNT_W     = $clog2(INS_COUNT) + 1;
    localparam int unsigned RN_W      = $clog2(RET_COUNT) + 1;
    localparam int unsigned ALLOC_MAX = DEPTH - INS_COUNT;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_alloc_ready;
    logic              r_exc_flush;

    logic              r_done       [DEPTH];
    logic              r_exc        [DEPTH];
    logic [DATA_W-1:0] r_data       [DEPTH];
    logic [REG_W-1:0]  r_dest_reg   [DEPTH];
    logic              r_dest_valid [DEPTH];

    logic [IDX_W-1:0]  w_ret_slot [RET_COUNT];
    logic              w_ret_vld  [RET_COUNT];
    logic [RN_W-1:0]   w_ret_num;
    logic              w_ret_exc_any;

    logic              w_exc_clear;
    logic [PTR_W-1:0]  w_head_ret;
    logic [PTR_W-1:0]  w_head_nxt;
    logic [PTR_W-1:0]  w_tail_nxt;
    logic [PTR_W-1:0]  w_count_nxt;
    logic [IDX_W-1:0]  w_flush_off;
    logic              w_flush_hit;
    logic              w_alloc_fire;

    logic [IDX_W-1:0]  w_alloc_slot [INS_COUNT];
    logic              w_alloc_lane [INS_COUNT];
    logic [IDX_W-1:0]  w_wb_off     [WR_COUNT];
    logic              w_wb_live    [WR_COUNT];

    // Retire lanes: contiguous done entries from head, stopping after an exception entry.
    always_comb begin
        logic w_ok;
        w_ok          = 1'b1;
        w_ret_num     = '0;
        w_ret_exc_any = 1'b0;
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            w_ret_slot[i] = r_head[IDX_W-1:0] + IDX_W'(i);
            w_ret_vld[i]  = w_ok && (PTR_W'(i) < r_count) && r_done[w_ret_slot[i]];
            w_ok          = w_ret_vld[i] && !r_exc[w_ret_slot[i]];
            w_ret_num     = w_ret_num + RN_W'(w_ret_vld[i]);
            w_ret_exc_any = w_ret_exc_any | (w_ret_vld[i] & r_exc[w_ret_slot[i]]);
        end
    end

    // Pointer update; exception clear outranks flush, flush outranks allocation.
    always_comb begin
        w_exc_clear  = rob.ret_ready && w_ret_exc_any;
        w_head_ret   = rob.ret_ready ? (r_head + PTR_W'(w_ret_num)) : r_head;
        w_flush_off  = rob.flush_idx - r_head[IDX_W-1:0];
        w_flush_hit  = rob.flush_req && (PTR_W'(w_flush_off) < r_count);
        w_alloc_fire = rob.alloc_req && r_alloc_ready && (rob.alloc_count != '0)
                       && !rob.flush_req && !w_exc_clear;
        w_head_nxt   = w_head_ret;
        w_tail_nxt   = r_tail;
        if (w_exc_clear) begin
            w_tail_nxt = w_head_ret;
        end else if (w_flush_hit) begin
            w_tail_nxt = r_head + PTR_W'(w_flush_off) + PTR_W'(1);
        end else if (w_alloc_fire) begin
            w_tail_nxt = r_tail + PTR_W'(rob.alloc_count);
        end
        w_count_nxt = w_tail_nxt - w_head_nxt;
    end

    // Allocation lanes and writeback liveness, both judged on pre-update state.
    always_comb begin
        for (int i = 0; i < int'(INS_COUNT); i++) begin
            w_alloc_slot[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
            w_alloc_lane[i] = w_alloc_fire && (CNT_W'(i) < rob.alloc_count);
        end
        for (int p = 0; p < int'(WR_COUNT); p++) begin
            w_wb_off[p]  = rob.wb_idx[p] - r_head[IDX_W-1:0];
            w_wb_live[p] = rob.wb_valid[p] && (PTR_W'(w_wb_off[p]) < r_count) && !w_exc_clear
                           && !(w_flush_hit && (w_wb_off[p] > w_flush_off));
        end
    end

    // Control state; a later writeback port overrides an earlier one on the same slot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_alloc_ready <= 1'b1;
            r_exc_flush   <= 1'b0;
            for (int d = 0; d < int'(DEPTH); d++) begin
                r_done[d] <= 1'b0;
                r_exc[d]  <= 1'b0;
            end
        end else begin
            r_head        <= w_head_nxt;
            r_tail        <= w_tail_nxt;
            r_count       <= w_count_nxt;
            r_empty       <= (w_count_nxt == '0);
            r_full        <= (w_count_nxt == PTR_W'(DEPTH));
            r_alloc_ready <= (w_count_nxt <= PTR_W'(ALLOC_MAX));
            r_exc_flush   <= w_exc_clear;
            for (int i = 0; i < int'(INS_COUNT); i++) begin
                if (w_alloc_lane[i]) begin
                    r_done[w_alloc_slot[i]] <= 1'b0;
                    r_exc[w_alloc_slot[i]]  <= 1'b0;
                end
            end
            for (int p = 0; p < int'(WR_COUNT); p++) begin
                if (w_wb_live[p]) begin
                    r_done[rob.wb_idx[p]] <= 1'b1;
                    r_exc[rob.wb_idx[p]]  <= rob.wb_exc[p];
                end
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind done.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(INS_COUNT); i++) begin
            if (w_alloc_lane[i]) begin
                r_dest_reg[w_alloc_slot[i]]   <= rob.alloc_dest_reg[i];
                r_dest_valid[w_alloc_slot[i]] <= rob.alloc_dest_valid[i];
            end
        end
        for (int p = 0; p < int'(WR_COUNT); p++) begin
            if (w_wb_live[p]) begin
                r_data[rob.wb_idx[p]] <= rob.wb_data[p];
            end
        end
    end

    assign rob.alloc_ready = r_alloc_ready;
    assign rob.exc_flush   = r_exc_flush;
    assign rob.count       = r_count;
    assign rob.empty       = r_empty;
    assign rob.full        = r_full;

    always_comb begin
        for (int i = 0; i < int'(INS_COUNT); i++) begin
            rob.alloc_idx[i] = w_alloc_slot[i];
        end
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            rob.ret_valid[i]      = w_ret_vld[i];
            rob.ret_idx[i]        = w_ret_slot[i];
            rob.ret_dest_reg[i]   = r_dest_reg[w_ret_slot[i]];
            rob.ret_dest_valid[i] = r_dest_valid[w_ret_slot[i]];
            rob.ret_data[i]       = r_data[w_ret_slot[i]];
            rob.ret_exc[i]        = r_exc[w_ret_slot[i]];
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus hand-written multi-cycle sequences
// and a queue model for the fill/wrap/retire-order run.
module tb_reorder_buffer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NL    = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    reorder_buffer_if #(.DEPTH(DEPTH), .INS_COUNT(NL), .WR_COUNT(NL), .RET_COUNT(NL),
                        .DATA_W(32), .REG_W(5)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .INS_COUNT(NL), .WR_COUNT(NL), .RET_COUNT(NL),
                     .DATA_W(32), .REG_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rob     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       areq;
        logic [2:0] acnt;
        logic       wbv;
        logic [3:0] wbi;
        logic       wbe;
        logic       fl;
        logic [3:0] fli;
        logic       rr;
        logic [4:0] e_cnt;
        logic [3:0] e_rv;
        logic       e_xf;
        logic       e_ar;
        logic       e_empty;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req   = 1'b0;
        bus.alloc_count = '0;
        bus.flush_req   = 1'b0;
        bus.flush_idx   = '0;
        bus.ret_ready   = 1'b0;
        for (int i = 0; i < int'(NL); i++) begin
            bus.alloc_dest_reg[i]   = 5'(i + 1);
            bus.alloc_dest_valid[i] = 1'b1;
            bus.wb_valid[i]         = 1'b0;
            bus.wb_idx[i]           = '0;
            bus.wb_data[i]          = '0;
            bus.wb_exc[i]           = 1'b0;
        end
    endtask

    task automatic alloc(input int k);
        bus.alloc_req   = 1'b1;
        bus.alloc_count = 3'(k);
    endtask

    task automatic wb(input int p, input int slot, input logic [31:0] d, input logic e);
        bus.wb_valid[p] = 1'b1;
        bus.wb_idx[p]   = 4'(slot);
        bus.wb_data[p]  = d;
        bus.wb_exc[p]   = e;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic logic [3:0] rv();
        logic [3:0] r;
        for (int i = 0; i < int'(NL); i++) r[i] = bus.ret_valid[i];
        return r;
    endfunction

    function automatic vec_t mk(input logic areq, input int acnt, input logic wbv, input int wbi,
                                input logic wbe, input logic fl, input int fli, input logic rr,
                                input int cnt, input logic [3:0] erv, input logic xf,
                                input logic ar, input logic emp);
        vec_t v;
        v.areq = areq; v.acnt = 3'(acnt); v.wbv = wbv; v.wbi = 4'(wbi); v.wbe = wbe;
        v.fl = fl; v.fli = 4'(fli); v.rr = rr;
        v.e_cnt = 5'(cnt); v.e_rv = erv; v.e_xf = xf; v.e_ar = ar; v.e_empty = emp;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 64'(bus.count), 64'(0));
        check({tag, "_empty"}, 64'(bus.empty), 64'(1));
        check({tag, "_full"}, 64'(bus.full), 64'(0));
        check({tag, "_ready"}, 64'(bus.alloc_ready), 64'(1));
        check({tag, "_rv"}, 64'(rv()), 64'(0));
        check({tag, "_xf"}, 64'(bus.exc_flush), 64'(0));
        for (int i = 0; i < int'(NL); i++) check({tag, "_aidx"}, 64'(bus.alloc_idx[i]), 64'(i));
    endtask

    int q_seq[$];
    bit q_done[$];

    initial begin
        int next_seq, retired, n, cnt, k, nwb;
        int wb_pos[4];
        logic rr;

        // Basic dispatch / out-of-order writeback / flush / exception sequence.
        tbl[0]  = mk(1, 4, 0, 0, 0, 0, 0, 0,  4, 4'b0000, 0, 1, 0);
        tbl[1]  = mk(0, 0, 1, 3, 0, 0, 0, 0,  4, 4'b0000, 0, 1, 0);
        tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0,  4, 4'b0000, 0, 1, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0,  4, 4'b0011, 0, 1, 0);
        tbl[4]  = mk(0, 0, 1, 2, 0, 0, 0, 0,  4, 4'b1111, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 4'b0000, 0, 1, 1);
        tbl[6]  = mk(1, 4, 0, 0, 0, 0, 0, 0,  4, 4'b0000, 0, 1, 0);
        tbl[7]  = mk(1, 4, 0, 0, 0, 1, 5, 0,  2, 4'b0000, 0, 1, 0);
        tbl[8]  = mk(0, 0, 1, 6, 0, 0, 0, 0,  2, 4'b0000, 0, 1, 0);
        tbl[9]  = mk(0, 0, 1, 4, 0, 0, 0, 0,  2, 4'b0001, 0, 1, 0);
        tbl[10] = mk(0, 0, 1, 5, 1, 0, 0, 0,  2, 4'b0011, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 4'b0000, 1, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 1, 1);
        tbl[13] = mk(1, 3, 0, 0, 0, 0, 0, 0,  3, 4'b0000, 0, 1, 0);

        do_reset();
        check_reset_state("rst");

        for (int v = 0; v < 14; v++) begin
            if (tbl[v].areq) alloc(int'(tbl[v].acnt));
            if (tbl[v].wbv) wb(0, int'(tbl[v].wbi), 32'h100 + 32'(tbl[v].wbi), tbl[v].wbe);
            bus.flush_req = tbl[v].fl;
            bus.flush_idx = tbl[v].fli;
            bus.ret_ready = tbl[v].rr;
            tick();
            idle();
            check($sformatf("v%0d_count", v), 64'(bus.count), 64'(tbl[v].e_cnt));
            check($sformatf("v%0d_rv", v), 64'(rv()), 64'(tbl[v].e_rv));
            check($sformatf("v%0d_xf", v), 64'(bus.exc_flush), 64'(tbl[v].e_xf));
            check($sformatf("v%0d_ready", v), 64'(bus.alloc_ready), 64'(tbl[v].e_ar));
            check($sformatf("v%0d_empty", v), 64'(bus.empty), 64'(tbl[v].e_empty));
            if (v == 4) begin
                check("v4_data3", 64'(bus.ret_data[3]), 64'(32'h103));
                check("v4_dest2", 64'(bus.ret_dest_reg[2]), 64'(3));
            end
            if (v == 10) check("v10_exc1", 64'(bus.ret_exc[1]), 64'(1));
        end
        check("tbl_aidx0", 64'(bus.alloc_idx[0]), 64'(9));
        check("tbl_aidx3", 64'(bus.alloc_idx[3]), 64'(12));

        // Walk head to 14, then flush across the wrap and raise an exception.
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            k = (blk < 3) ? 4 : 2;
            alloc(k);
            tick(); idle();
            for (int j = 0; j < k; j++) wb(j, blk * 4 + j, 32'(blk * 4 + j), 1'b0);
            tick(); idle();
            bus.ret_ready = 1'b1;
            tick(); idle();
        end
        check("h14_count", 64'(bus.count), 64'(0));
        check("h14_ridx", 64'(bus.ret_idx[0]), 64'(14));
        alloc(4); tick(); idle();
        alloc(4); tick(); idle();
        check("h14_count8", 64'(bus.count), 64'(8));
        bus.flush_req = 1'b1;
        bus.flush_idx = 4'd1;
        tick(); idle();
        check("flush_count", 64'(bus.count), 64'(4));
        check("flush_aidx", 64'(bus.alloc_idx[0]), 64'(2));
        wb(0, 3, 32'hdead, 1'b0);
        tick(); idle();
        check("dead_wb_count", 64'(bus.count), 64'(4));
        check("dead_wb_rv", 64'(rv()), 64'(4'b0000));
        wb(0, 14, 32'h14, 1'b0);
        wb(1, 15, 32'h15, 1'b1);
        wb(2, 0, 32'h20, 1'b0);
        wb(3, 1, 32'h21, 1'b0);
        tick(); idle();
        check("exc_rv", 64'(rv()), 64'(4'b0011));
        check("exc_lane1", 64'(bus.ret_exc[1]), 64'(1));
        check("exc_lane0", 64'(bus.ret_exc[0]), 64'(0));
        check("exc_ridx1", 64'(bus.ret_idx[1]), 64'(15));
        bus.ret_ready = 1'b1;
        tick(); idle();
        check("excclr_count", 64'(bus.count), 64'(0));
        check("excclr_empty", 64'(bus.empty), 64'(1));
        check("excclr_xf", 64'(bus.exc_flush), 64'(1));
        check("excclr_rv", 64'(rv()), 64'(4'b0000));
        check("excclr_aidx", 64'(bus.alloc_idx[0]), 64'(0));
        tick();
        check("excclr_xf_pulse", 64'(bus.exc_flush), 64'(0));

        // Same-cycle alloc + flush + retire, then dual writeback to one slot.
        alloc(4); tick(); idle();
        alloc(4); tick(); idle();
        wb(0, 0, 32'h30, 1'b0);
        wb(1, 1, 32'h31, 1'b0);
        tick(); idle();
        check("mix_rv", 64'(rv()), 64'(4'b0011));
        bus.ret_ready = 1'b1;
        bus.flush_req = 1'b1;
        bus.flush_idx = 4'd5;
        alloc(4);
        tick(); idle();
        check("mix_count", 64'(bus.count), 64'(4));
        check("mix_aidx", 64'(bus.alloc_idx[0]), 64'(6));
        check("mix_ridx", 64'(bus.ret_idx[0]), 64'(2));
        check("mix_rv0", 64'(rv()), 64'(4'b0000));
        wb(0, 2, 32'h32, 1'b0);
        wb(1, 5, 32'haaaa, 1'b0);
        wb(2, 3, 32'h33, 1'b0);
        wb(3, 5, 32'hbbbb, 1'b0);
        tick(); idle();
        check("dual_rv", 64'(rv()), 64'(4'b0011));
        wb(0, 4, 32'h34, 1'b0);
        tick(); idle();
        check("dual_rv_all", 64'(rv()), 64'(4'b1111));
        check("dual_data", 64'(bus.ret_data[3]), 64'(32'hbbbb));

        // Fill to full, then stream 40 allocations with retire; model is a FIFO of sequence numbers.
        do_reset();
        next_seq = 0;
        retired  = 0;
        q_seq.delete();
        q_done.delete();
        for (int cyc = 0; cyc < 200 && retired < 40; cyc++) begin
            cnt = q_seq.size();
            n = 0;
            while (n < 4 && n < cnt && q_done[n]) n++;
            check("wrap_count", 64'(bus.count), 64'(cnt));
            check("wrap_ready", 64'(bus.alloc_ready), 64'(cnt <= 12));
            check("wrap_full", 64'(bus.full), 64'(cnt == 16));
            for (int i = 0; i < 4; i++) begin
                check("wrap_rv", 64'(bus.ret_valid[i]), 64'(i < n));
                if (i < n) begin
                    check("wrap_data", 64'(bus.ret_data[i]), 64'(q_seq[i]));
                    check("wrap_ridx", 64'(bus.ret_idx[i]), 64'(q_seq[i] % 16));
                    check("wrap_dest", 64'(bus.ret_dest_reg[i]), 64'(q_seq[i] % 32));
                    check("wrap_dvld", 64'(bus.ret_dest_valid[i]), 64'(q_seq[i] % 2));
                end
            end
            rr = (next_seq >= 16);
            bus.ret_ready = rr;
            k = (cnt <= 12 && next_seq < 40) ? 4 : 0;
            if (k > 0) begin
                alloc(k);
                for (int i = 0; i < 4; i++) begin
                    bus.alloc_dest_reg[i]   = 5'((next_seq + i) % 32);
                    bus.alloc_dest_valid[i] = 1'((next_seq + i) % 2);
                end
            end
            nwb = 0;
            for (int j = 0; j < cnt && nwb < 4; j++) begin
                if (!q_done[j]) begin
                    wb(nwb, q_seq[j] % 16, 32'(q_seq[j]), 1'b0);
                    wb_pos[nwb] = j;
                    nwb++;
                end
            end
            tick();
            idle();
            for (int w = 0; w < nwb; w++) q_done[wb_pos[w]] = 1'b1;
            if (rr) begin
                for (int r = 0; r < n; r++) begin
                    void'(q_seq.pop_front());
                    void'(q_done.pop_front());
                    retired++;
                end
            end
            for (int i = 0; i < k; i++) begin
                q_seq.push_back(next_seq);
                q_done.push_back(1'b0);
                next_seq++;
            end
        end
        check("wrap_retired", 64'(retired), 64'(40));

        // Reset in the middle of traffic.
        do_reset();
        alloc(4); tick(); idle();
        alloc(4); tick(); idle();
        alloc(2); tick(); idle();
        check("midrst_count10", 64'(bus.count), 64'(10));
        reset_n = 1'b0;
        for (int p = 0; p < 4; p++) wb(p, p, 32'h50 + 32'(p), 1'b0);
        alloc(4);
        tick(); idle();
        reset_n = 1'b1;
        check_reset_state("midrst");
        tick();
        check("midrst_rv_after", 64'(rv()), 64'(4'b0000));
        check("midrst_count_after", 64'(bus.count), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order-retire reorder buffer for the out-of-order core; the next generation of the existing ROB. It allocates up to INS_COUNT slots per cycle at dispatch and accepts up to WR_COUNT out-of-order writebacks. It retires up to RET_COUNT contiguous completed entries per cycle to the register file. Compared to the previous block it adds wrap-bit pointers (all DEPTH slots usable), pointer-rewind flush, per-entry exception tracking with automatic full-buffer clear, and self-computed retire width.

## Interface
- DEPTH, 16: entry count; power of 2, >= 4
- INS_COUNT, 4: allocation lanes
- WR_COUNT, 4: writeback ports
- RET_COUNT, 4: retire lanes
- DATA_W, 32: result width
- REG_W, 5: architectural register index width
- IDX_W = clog2(DEPTH); CNT_W = clog2(INS_COUNT)+1

Ports. Arrays are unpacked, one element per lane. One clock; reset is synchronous, active-low.
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset
- alloc_req  in  1  allocate alloc_count slots this cycle
- alloc_count  in  CNT_W  slots requested, 1..INS_COUNT; 0 = none
- alloc_dest_reg[INS_COUNT]  in  REG_W  destination per lane
- alloc_dest_valid[INS_COUNT]  in  1  lane writes a register
- alloc_ready  out  1  free slots >= INS_COUNT
- alloc_idx[INS_COUNT]  out  IDX_W  slot index lane i will receive
- wb_valid[WR_COUNT]  in  1  writeback strobe
- wb_idx[WR_COUNT]  in  IDX_W  target slot
- wb_data[WR_COUNT]  in  DATA_W  result
- wb_exc[WR_COUNT]  in  1  instruction raised exception
- flush_req  in  1  discard all entries strictly younger than flush_idx
- flush_idx  in  IDX_W  youngest surviving slot
- ret_ready  in  1  consumer accepts every lane with ret_valid set
- ret_valid[RET_COUNT]  out  1  lane retirable
- ret_idx[RET_COUNT], ret_dest_reg, ret_dest_valid, ret_data, ret_exc  out  per-lane entry contents
- exc_flush  out  1  registered pulse: buffer was cleared by exception retire
- count  out  IDX_W+1  live entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Pointers head/tail are IDX_W+1 bits with a wrap bit. count = tail-head. Slot index = low IDX_W bits.
- Allocation fires when alloc_req && alloc_ready && alloc_count!=0 && !flush_req && !exc_clear.
  - alloc_idx[i] = tail+i, always driven.
  - Slot gets dest fields; done and exc are cleared.
  - tail += alloc_count.
- Writeback: slot is live iff (wb_idx-head) mod DEPTH < count, using pre-update state.
  - Live writeback: data stored, done=1, exc=wb_exc.
  - Non-live writeback: ignored.
  - Two ports hitting the same slot in one cycle: the higher port index wins.
- Retire: ret_valid[i]=1 iff all of the following hold:
  - i < count;
  - done[head+i] is set;
  - ret_valid[i-1] is set (i>0);
  - exc[head+i-1] is clear (i>0).
  - An exception entry is therefore the last lane presented.
  - ret_valid does not depend on ret_ready.
  - On ret_ready, head += number of set ret_valid lanes.
- exc_clear = ret_ready && some ret_valid lane has ret_exc.
  - Next cycle: head=tail=old head+retired lanes; all younger entries are discarded.
  - exc_flush pulses for 1 cycle.
- Flush: off = (flush_idx-head[IDX_W-1:0]) mod DEPTH.
  - If off < count: tail = head + off + 1, computed from pre-retire head.
  - Else: ignored.

## Timing
- Reset (reset_n low at a clock edge):
  - head=tail=0; count=0, empty=1, full=0, alloc_ready=1.
  - All ret_valid=0, exc_flush=0, all done/exc=0.
  - Reset mid-operation discards everything the same edge.
- All outputs except alloc_idx/ret_* contents are functions of registered state only. No input-to-output combinational paths.
- Writeback to retire: entry visible on ret_valid the cycle after the wb edge. No bypass.
- Allocation to writeback: a slot is live from the cycle after allocation. A same-cycle wb to it is ignored.
- Priority, highest first: reset > exc_clear > flush > allocation.
  - Retire completes in the same cycle as a flush.
  - A wb to a slot being killed by flush/exc_clear is dropped.
- Wrap: pointers wrap modulo 2*DEPTH; full (count==DEPTH) is distinguishable from empty.
- Throughput: INS_COUNT allocs, WR_COUNT writebacks, RET_COUNT retires per cycle, all concurrent.

## Test plan
- Reset, then alloc 4 (regs 1..4) -> alloc_idx 0..3, count=4 next cycle. Wb slots 3,1,0 -> ret_valid=1,1,0,0; after wb 2 -> 1,1,1,1.
- Fill 16 entries, retire with ret_ready=1 until the 40th allocation -> full asserts exactly at count=16, alloc_ready=0 at count>12, indices wrap 15->0, retired order is 0..39.
- 8 entries live at head=14, flush_idx=1 -> tail=head+4, count=4; wb to slot 3 next cycle ignored.
- Wb slot head+1 with wb_exc=1, all four done -> ret_valid=1,1,0,0 with ret_exc on lane 1; ret_ready -> count=0, exc_flush=1 for one cycle.
- Same-cycle alloc+flush+retire 2 -> allocation dropped, head+=2, tail from flush. Dual wb to slot 5 -> port 3 data stored.
- reset_n low while count=10 with pending wbs -> all outputs back to reset values next edge.
